// File: rtl/rx_buffer_manager_if.sv
// Bus bundle between the USB RX control unit / host read side and the
// packet-aware byte buffer. The buffer itself is the slave.
interface rx_buffer_manager_if #(
  parameter int ADDR_W = 6
);
  logic              rx_store;
  logic [7:0]        rx_data;
  logic              rx_commit;
  logic              rx_abort;
  logic              flush;
  logic              host_read;
  logic [7:0]        host_data;
  logic              data_available;
  logic [ADDR_W:0]   committed_count;
  logic [ADDR_W:0]   pending_count;
  logic              buffer_full;
  logic              rx_overflow_err;
  logic              rd_underflow_err;
  logic              rx_busy;

  modport slave (
    input  rx_store, rx_data, rx_commit, rx_abort, flush, host_read,
    output host_data, data_available, committed_count, pending_count,
           buffer_full, rx_overflow_err, rd_underflow_err, rx_busy
  );

  modport master (
    output rx_store, rx_data, rx_commit, rx_abort, flush, host_read,
    input  host_data, data_available, committed_count, pending_count,
           buffer_full, rx_overflow_err, rd_underflow_err, rx_busy
  );
endinterface

// File: rtl/rx_buffer_manager.sv
// Packet-aware RX byte buffer: tentative writes, commit/rollback, host reads.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | no packet in progress, nothing pending
// ST_RECEIVING | bytes of the current packet are being stored (pending)
// ST_OVERFLOW  | packet hit a full buffer; drop bytes until commit/abort
module rx_buffer_manager #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 n_rst,
  rx_buffer_manager_if.slave   bus
);

  typedef logic [ADDR_W:0] ptr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RECEIVING, ST_OVERFLOW} state_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  logic [7:0] mem [DEPTH];

  ptr_t   wptr_q, cptr_q, rptr_q;
  state_t state_q;
  logic   ovf_err_q, und_err_q;

  ptr_t committed, pending, total, wptr_d;
  logic full, avail, store_ok, store_blocked, read_ok;

  // Occupancy from pointer differences; the wrap bit makes full vs empty unambiguous
  always_comb begin
    committed     = cptr_q - rptr_q;
    pending       = wptr_q - cptr_q;
    total         = wptr_q - rptr_q;
    full          = (total == DEPTH_P);
    avail         = (committed != '0);
    // Full check uses pre-edge pointers, so a same-cycle read frees nothing
    store_ok      = bus.rx_store && !full && (state_q != ST_OVERFLOW) && !bus.flush;
    store_blocked = bus.rx_store && full;
    read_ok       = bus.host_read && avail;
    wptr_d        = store_ok ? (wptr_q + PTR_ONE) : wptr_q;
  end

  // Storage array: no reset, written only for accepted bytes
  always_ff @(posedge clk) begin
    if (store_ok) mem[wptr_q[ADDR_W-1:0]] <= bus.rx_data;
  end

  // Packet FSM with pointers and registered error pulses; flush overrides everything
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q    <= '0;
      cptr_q    <= '0;
      rptr_q    <= '0;
      state_q   <= ST_IDLE;
      ovf_err_q <= 1'b0;
      und_err_q <= 1'b0;
    end else if (bus.flush) begin
      wptr_q    <= '0;
      cptr_q    <= '0;
      rptr_q    <= '0;
      state_q   <= ST_IDLE;
      ovf_err_q <= 1'b0;
      und_err_q <= 1'b0;
    end else begin
      ovf_err_q <= 1'b0;
      und_err_q <= bus.host_read && !avail;
      if (read_ok) rptr_q <= rptr_q + PTR_ONE;
      wptr_q <= wptr_d;
      case (state_q)
        ST_IDLE, ST_RECEIVING: begin
          // Abort wins over commit; a same-cycle stored byte is rolled back with it
          if (bus.rx_abort) begin
            wptr_q  <= cptr_q;
            state_q <= ST_IDLE;
          end else if (bus.rx_commit) begin
            cptr_q  <= wptr_d;
            state_q <= ST_IDLE;
          end else if (store_ok) begin
            state_q <= ST_RECEIVING;
          end else if (store_blocked) begin
            state_q <= ST_OVERFLOW;
          end
        end
        ST_OVERFLOW: begin
          // Whatever ends the packet, a truncated packet is never committed
          if (bus.rx_commit || bus.rx_abort) begin
            wptr_q    <= cptr_q;
            state_q   <= ST_IDLE;
            ovf_err_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // First-word fall-through read and status outputs
  always_comb begin
    bus.host_data        = mem[rptr_q[ADDR_W-1:0]];
    bus.data_available   = avail;
    bus.committed_count  = committed;
    bus.pending_count    = pending;
    bus.buffer_full      = full;
    bus.rx_overflow_err  = ovf_err_q;
    bus.rd_underflow_err = und_err_q;
    bus.rx_busy          = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_rx_buffer_manager.sv
// Bench for rx_buffer_manager: directed scenarios plus random traffic,
// checked against a queue-based packet model.
module tb_rx_buffer_manager;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk;
  logic n_rst;
  int   checks   = 0;
  int   failures = 0;

  rx_buffer_manager_if #(.ADDR_W(ADDR_W)) bus ();

  rx_buffer_manager #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed bytes, pending bytes, packet mode
  byte unsigned cq[$];
  byte unsigned pq[$];
  int           mode;      // 0 idle, 1 receiving, 2 overflow
  bit           e_ovf, e_und;

  task automatic model_reset();
    cq.delete();
    pq.delete();
    mode  = 0;
    e_ovf = 0;
    e_und = 0;
  endtask

  task automatic model_step(bit s, byte unsigned d, bit c, bit a, bit f, bit r);
    bit full, acc;
    e_ovf = 0;
    e_und = 0;
    if (f) begin
      cq.delete();
      pq.delete();
      mode = 0;
      return;
    end
    full = (cq.size() + pq.size()) == DEPTH;
    acc  = s && !full && (mode != 2);
    if (r) begin
      if (cq.size() > 0) void'(cq.pop_front());
      else e_und = 1;
    end
    if (acc) pq.push_back(d);
    if (mode == 2) begin
      if (c || a) begin
        pq.delete();
        mode  = 0;
        e_ovf = 1;
      end
    end else if (a) begin
      pq.delete();
      mode = 0;
    end else if (c) begin
      while (pq.size() > 0) cq.push_back(pq.pop_front());
      mode = 0;
    end else if (acc) begin
      mode = 1;
    end else if (s && full) begin
      mode = 2;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("committed_count", 32'(bus.committed_count), cq.size());
    chk("pending_count",   32'(bus.pending_count),   pq.size());
    chk("data_available",  32'(bus.data_available),  32'(cq.size() > 0));
    chk("buffer_full",     32'(bus.buffer_full),     32'((cq.size() + pq.size()) == DEPTH));
    chk("rx_busy",         32'(bus.rx_busy),         32'(mode != 0));
    chk("rx_overflow_err", 32'(bus.rx_overflow_err), 32'(e_ovf));
    chk("rd_underflow_err",32'(bus.rd_underflow_err),32'(e_und));
    if (cq.size() > 0) chk("host_data", 32'(bus.host_data), 32'(cq[0]));
  endtask

  task automatic step(bit s, byte unsigned d, bit c, bit a, bit f, bit r);
    bus.rx_store  = s;
    bus.rx_data   = d;
    bus.rx_commit = c;
    bus.rx_abort  = a;
    bus.flush     = f;
    bus.host_read = r;
    @(posedge clk);
    model_step(s, d, c, a, f, r);
    #1;
    check_all();
  endtask

  task automatic idle();        step(0, 8'h00, 0, 0, 0, 0); endtask
  task automatic store(byte unsigned d); step(1, d, 0, 0, 0, 0); endtask
  task automatic commit();      step(0, 8'h00, 1, 0, 0, 0); endtask
  task automatic abort_pkt();   step(0, 8'h00, 0, 1, 0, 0); endtask
  task automatic rd();          step(0, 8'h00, 0, 0, 0, 1); endtask
  task automatic do_flush();    step(0, 8'h00, 0, 0, 1, 0); endtask

  initial begin
    bus.rx_store  = 0;
    bus.rx_data   = 0;
    bus.rx_commit = 0;
    bus.rx_abort  = 0;
    bus.flush     = 0;
    bus.host_read = 0;
    n_rst = 0;
    model_reset();
    #23;
    check_all();
    n_rst = 1;
    @(posedge clk);
    #1;

    // Basic commit
    store(8'hA1); store(8'hB2); store(8'hC3); commit();
    chk("basic_committed", 32'(bus.committed_count), 32'd3);
    chk("basic_first",     32'(bus.host_data),       32'hA1);
    rd(); rd(); rd();
    chk("basic_drained",   32'(bus.data_available),  32'd0);

    // Abort rollback
    store(8'h11); store(8'h22); commit();
    for (int i = 0; i < 5; i++) store(8'(8'h50 + i));
    abort_pkt();
    chk("abort_committed", 32'(bus.committed_count), 32'd2);
    rd(); rd(); idle();

    // Store+commit, store+abort, commit+abort
    store(8'h31); step(1, 8'h32, 1, 0, 0, 0);
    chk("store_commit_cnt", 32'(bus.committed_count), 32'd2);
    store(8'h33); step(1, 8'h34, 0, 1, 0, 0);
    store(8'h35); step(0, 8'h00, 1, 1, 0, 0);
    chk("commit_abort_cnt", 32'(bus.committed_count), 32'd2);
    rd(); rd();

    // Underflow pulse of one cycle
    rd();
    chk("underflow_pulse", 32'(bus.rd_underflow_err), 32'd1);
    idle();

    // Overflow of a 64-byte pending packet
    do_flush();
    for (int i = 0; i < DEPTH; i++) store(8'(i));
    chk("ovf_full", 32'(bus.buffer_full), 32'd1);
    store(8'hEE);
    store(8'hEF);
    commit();
    chk("ovf_pulse", 32'(bus.rx_overflow_err), 32'd1);
    idle();
    chk("ovf_pulse_end", 32'(bus.rx_overflow_err), 32'd0);

    // Read while full with a store
    for (int i = 0; i < DEPTH - 1; i++) store(8'(8'h80 + i));
    step(1, 8'hBF, 1, 0, 0, 0);
    chk("full_committed", 32'(bus.committed_count), 32'd64);
    step(1, 8'hCC, 0, 0, 0, 1);
    chk("read_full_cnt", 32'(bus.committed_count), 32'd63);
    abort_pkt();
    idle();

    // Wrap-around streaming of three 40-byte packets
    do_flush();
    store(8'hFF); commit(); rd();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 40; i++) store(8'(p * 40 + i));
      commit();
      for (int i = 0; i < 40; i++) rd();
    end

    // Flush with committed and pending data
    for (int i = 0; i < 10; i++) store(8'(8'h20 + i));
    commit();
    for (int i = 0; i < 4; i++) store(8'(8'h40 + i));
    do_flush();
    chk("flush_busy", 32'(bus.rx_busy), 32'd0);
    idle();

    // Asynchronous reset mid-packet
    store(8'h01); store(8'h02); commit(); store(8'h03);
    n_rst = 0;
    #2;
    model_reset();
    check_all();
    #1;
    n_rst = 1;
    idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit s, c, a, f, r;
      s = $urandom_range(99) < 60;
      c = $urandom_range(99) < 6;
      a = $urandom_range(99) < 3;
      f = $urandom_range(999) < 5;
      r = $urandom_range(99) < ((n / 500) % 2 == 0 ? 45 : 15);
      step(s, 8'($urandom), c, a, f, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
